// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC serial reader front end.
// Holds the transaction FSM state encoding, the default bank geometry and a
// helper that computes the minimum transaction length in clk cycles.
package adc_pkg;

  localparam int DEF_N_CH        = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_SCLK_DIV    = 2;
  localparam int DEF_CONV_CYCLES = 40;
  localparam int PERIOD_W        = 16;

  // One transaction walks IDLE -> CONV -> SHIFT -> LATCH -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

  // Cycles from the accepting tick to adcready rising: conversion time,
  // DATA_W full SCLK periods and the single LATCH cycle.
  function automatic int tmin(input int conv_cycles, input int sclk_div,
                              input int data_w);
    return conv_cycles + 2 * sclk_div * data_w + 1;
  endfunction

endpackage : adc_pkg

// File: rtl/adc_serial_reader_if.sv
// Output bus from the serial reader to the ADC accumulator: packed sample
// words, a per-channel ready level and the sticky overrun flag.
interface adc_serial_reader_if #(
  parameter int N_CH   = adc_pkg::DEF_N_CH,
  parameter int DATA_W = adc_pkg::DEF_DATA_W
);

  logic [N_CH*DATA_W-1:0] adcdata;
  logic [N_CH-1:0]        adcready;
  logic                   overrun;

  // The reader drives the bus.
  modport master (
    output adcdata,
    output adcready,
    output overrun
  );

  // The accumulator consumes it.
  modport slave (
    input adcdata,
    input adcready,
    input overrun
  );

endinterface : adc_serial_reader_if

// File: rtl/adc_sclk_gen.sv
// Serial clock generator for the ADC bank. On start it emits DATA_W SCLK
// pulses, each SCLK_DIV cycles high followed by SCLK_DIV cycles low, high
// phase first. capture pulses in the cycle whose closing edge drives sclk
// high->low; done pulses in the last cycle of the final low phase.
module adc_sclk_gen #(
  parameter int DATA_W   = adc_pkg::DEF_DATA_W,
  parameter int SCLK_DIV = adc_pkg::DEF_SCLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic sclk,
  output logic capture,
  output logic done
);

  localparam int PH_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic             active_q, active_d;
  logic             sclk_q, sclk_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             ph_last;

  // Phase and bit sequencing; strobes are decoded from the current state.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    active_d = active_q;
    sclk_d   = sclk_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    capture  = 1'b0;
    done     = 1'b0;
    ph_last  = (ph_q == PH_W'(SCLK_DIV - 1));

    if (start) begin
      active_d = 1'b1;
      sclk_d   = 1'b1;
      ph_d     = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (ph_last) begin
        ph_d = '0;
        if (sclk_q) begin
          sclk_d  = 1'b0;
          capture = 1'b1;
        end else if (bit_q == BIT_W'(DATA_W - 1)) begin
          active_d = 1'b0;
          done     = 1'b1;
        end else begin
          bit_d  = bit_q + 1'b1;
          sclk_d = 1'b1;
        end
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
  end

  // Generator state register; sclk leaves a flop so the pin is glitch free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      ph_q     <= '0;
      bit_q    <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so all update together.
      active_q <= active_d;
      sclk_q   <= sclk_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
    end
  end

  assign sclk = sclk_q;

endmodule : adc_sclk_gen

// File: rtl/adc_serial_reader.sv
// ADC serial reader: paces conversions from a runtime period register, drives
// CNV and the shared SCLK for a bank of N_CH SPI ADCs, shifts all SDO lines
// in parallel (MSB first) and presents the words to the accumulator.
// Build option: define ADC_OFFSET_BINARY_EN to invert each word's MSB at
// latch time (offset-binary ADCs); left undefined, words pass unchanged.
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SCLK_DIV    = DEF_SCLK_DIV,
  parameter int CONV_CYCLES = DEF_CONV_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [N_CH-1:0]     sdo,
  output logic                cnv,
  output logic                sclk,
  adc_serial_reader_if.master bus
);

  localparam int CONV_W = $clog2(CONV_CYCLES + 1);

`ifdef ADC_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] MSB_MASK = '0;
`endif

  state_e                 state_q, state_d;
  logic [PERIOD_W-1:0]    per_cnt_q, per_cnt_d;
  logic [PERIOD_W-1:0]    per_lim;
  logic                   tick;
  logic [CONV_W-1:0]      conv_cnt_q, conv_cnt_d;
  logic                   cnv_q, cnv_d;
  logic                   overrun_q, overrun_d;
  logic [N_CH-1:0]        ready_q, ready_d;
  logic [N_CH*DATA_W-1:0] data_q, data_d;
  logic [N_CH*DATA_W-1:0] word_fmt;
  logic                   shift_start;
  logic                   capture;
  logic                   shift_done;

  // Period counter: free-runs while enabled, ticks at max(period,1)-1.
  always_comb begin
    per_lim   = (period == '0) ? PERIOD_W'(1) : period;
    tick      = enable && (per_cnt_q >= per_lim - PERIOD_W'(1));
    per_cnt_d = per_cnt_q + 1'b1;
    if (!enable || tick) begin
      per_cnt_d = '0;
    end
  end

  // Transaction FSM next state; a tick is only accepted from IDLE.
  always_comb begin
    state_d     = state_q;
    conv_cnt_d  = '0;
    shift_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CONV;
        end
      end
      CONV: begin
        if (conv_cnt_q == CONV_W'(CONV_CYCLES - 1)) begin
          state_d     = SHIFT;
          shift_start = 1'b1;
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output-side next values: CNV level, ready/data handshake, overrun flag.
  always_comb begin
    cnv_d     = (state_d == CONV);
    ready_d   = ready_q;
    data_d    = data_q;
    // Back-to-back mode ticks every cycle by design, so it never flags.
    overrun_d = overrun_q | (tick && (state_q != IDLE) && (period != '0));
    if (shift_start) begin
      ready_d = '0;
    end
    if (state_q == LATCH) begin
      data_d  = word_fmt;
      ready_d = '1;
    end
  end

  // FSM and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      conv_cnt_q <= '0;
      cnv_q      <= 1'b0;
      overrun_q  <= 1'b0;
      ready_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      conv_cnt_q <= conv_cnt_d;
      cnv_q      <= cnv_d;
      overrun_q  <= overrun_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
    end
  end

  adc_sclk_gen #(
    .DATA_W   (DATA_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (shift_start),
    .sclk    (sclk),
    .capture (capture),
    .done    (shift_done)
  );

  // Per-channel shift registers, MSB arrives first.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DATA_W-1:0] sr_q, sr_d;

    // Shift one SDO bit in on each SCLK falling edge.
    always_comb begin
      sr_d = sr_q;
      if (capture) begin
        sr_d = {sr_q[DATA_W-2:0], sdo[k]};
      end
    end

    // Each transaction overwrites all DATA_W bits, so no clear is needed
    // between samples.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the shift register is reset so outputs are deterministic after
      // power-up; it costs nothing here since it is not a RAM.
      if (!rst_n) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign word_fmt[k*DATA_W +: DATA_W] = sr_q ^ MSB_MASK;
  end

  assign cnv          = cnv_q;
  assign bus.adcdata  = data_q;
  assign bus.adcready = ready_q;
  assign bus.overrun  = overrun_q;

endmodule : adc_serial_reader

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: reset values, timing of CNV/SCLK,
// word capture, overrun, back-to-back, disable and reset mid-shift.
module tb_adc_serial_reader;

  localparam int N_CH = 16;
  localparam int DW   = 16;

`ifdef ADC_OFFSET_BINARY_EN
  localparam logic [15:0] MSB_FLIP = 16'h8000;
`else
  localparam logic [15:0] MSB_FLIP = 16'h0000;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [15:0]     period;
  logic [N_CH-1:0] sdo;
  logic            cnv;
  logic            sclk;

  int n_checks = 0;
  int n_errors = 0;

  adc_serial_reader_if #(.N_CH(N_CH), .DATA_W(DW)) bus ();

  adc_serial_reader #(
    .N_CH        (N_CH),
    .DATA_W      (DW),
    .SCLK_DIV    (2),
    .CONV_CYCLES (40)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .period (period),
    .sdo    (sdo),
    .cnv    (cnv),
    .sclk   (sclk),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ADC model: loads its word when CNV falls, shifts on each SCLK fall.
  logic [15:0] adc_word [N_CH];
  logic [15:0] adc_sr   [N_CH];
  logic        prev_cnv  = 1'b0;
  logic        prev_sclk = 1'b0;

  always @(posedge clk) begin
    #1;
    if (prev_cnv && !cnv) begin
      for (int k = 0; k < N_CH; k++) adc_sr[k] = adc_word[k];
    end else if (prev_sclk && !sclk) begin
      for (int k = 0; k < N_CH; k++) adc_sr[k] = adc_sr[k] << 1;
    end
    prev_cnv  = cnv;
    prev_sclk = sclk;
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) sdo[k] = adc_sr[k][15];
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int k);
    return adc_word[k] ^ MSB_FLIP;
  endfunction

  // Follow one transaction from the current point and check its timing
  // and the captured words.
  task automatic run_txn(input string tag, input int exp_wait);
    int          w;
    int          conv_w;
    int          highs;
    int          rises;
    int          pat_err;
    int          nr;
    logic        s;
    logic        prev;
    logic        want;
    logic [15:0] r0;

    w = 0;
    while (cnv !== 1'b1 && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_wait"}, 32'(w), 32'(exp_wait));
    if (cnv !== 1'b1) return;

    conv_w = 0;
    do begin
      @(posedge clk); #1; conv_w++;
    end while (cnv === 1'b1 && conv_w < 200);
    check({tag, "_cnv_width"}, 32'(conv_w), 32'd40);

    r0      = bus.adcready;
    highs   = 0;
    rises   = 0;
    pat_err = 0;
    prev    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      s     = sclk;
      want  = ((i % 4) < 2);
      highs += int'(s);
      if (s && !prev) rises++;
      if (s !== want) pat_err++;
      prev = s;
    end
    check({tag, "_ready_drop"}, 32'(r0), 32'h0);
    check({tag, "_sclk_high"}, 32'(highs), 32'd32);
    check({tag, "_sclk_pulses"}, 32'(rises), 32'd16);
    check({tag, "_sclk_shape"}, 32'(pat_err), 32'd0);

    nr = 0;
    while (bus.adcready !== 16'hffff && nr < 20) begin
      @(posedge clk); #1; nr++;
    end
    check({tag, "_tmin"}, 32'(conv_w + 63 + nr), 32'd105);
    for (int k = 0; k < N_CH; k++) begin
      check($sformatf("%s_word%0d", tag, k),
            32'(bus.adcdata[k*DW +: DW]), 32'(exp_word(k)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    enable = 1'b0;
    period = 16'd200;
    for (int k = 0; k < N_CH; k++) adc_word[k] = 16'h1000 + 16'(k);

    repeat (3) @(posedge clk);
    #1;
    check("rst_cnv", 32'(cnv), 32'h0);
    check("rst_sclk", 32'(sclk), 32'h0);
    check("rst_ready", 32'(bus.adcready), 32'h0);
    check("rst_data_or", 32'(|bus.adcdata), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;

    // Normal run at period 200.
    run_txn("norm1", 200);
    run_txn("norm2", 95);

    // Signed and MSB-first pattern, plus offset-binary edge words.
    adc_word[0] = 16'h28ee;
    adc_word[1] = 16'hfe00;
    adc_word[2] = 16'h0020;
    adc_word[3] = 16'hffd0;
    adc_word[4] = 16'h8000;
    adc_word[5] = 16'h0000;
    for (int k = 6; k < N_CH; k++) adc_word[k] = 16'h8001 + 16'(k);
    run_txn("sgn", 95);

    // Back-to-back: next CNV one cycle after adcready rises.
    period = 16'd0;
    run_txn("b2b1", 1);
    run_txn("b2b2", 1);
    check("b2b_no_overrun", 32'(bus.overrun), 32'h0);

    // Drop enable during SHIFT: that word still latches, then silence.
    n = 0;
    while (cnv !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n = 0;
    while (cnv === 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b0;
    n = 0;
    while (bus.adcready !== 16'hffff && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("dis_ready", 32'(bus.adcready), 32'hffff);
    check("dis_word0", 32'(bus.adcdata[0 +: DW]), 32'(exp_word(0)));
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (cnv === 1'b1) n++;
    end
    check("dis_no_cnv", 32'(n), 32'd0);
    check("dis_ready_hold", 32'(bus.adcready), 32'hffff);

    // Overrun at period 50.
    period = 16'd50;
    enable = 1'b1;
    run_txn("ovr1", 50);
    check("ovr_flag", 32'(bus.overrun), 32'h1);
    run_txn("ovr2", 45);
    check("ovr_sticky", 32'(bus.overrun), 32'h1);

    // Reset in the middle of SHIFT, then a clean first transaction.
    period = 16'd200;
    n = 0;
    while (cnv !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    n = 0;
    while (cnv === 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cnv", 32'(cnv), 32'h0);
    check("mid_rst_sclk", 32'(sclk), 32'h0);
    check("mid_rst_ready", 32'(bus.adcready), 32'h0);
    check("mid_rst_data_or", 32'(|bus.adcdata), 32'h0);
    check("mid_rst_overrun", 32'(bus.overrun), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("post_rst", 200);
    check("post_rst_overrun", 32'(bus.overrun), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_adc_serial_reader
